fault_response_checker: RTL

Downstream stage of the combinational fault-injection harness. It consumes the DUT output and the golden value from each test vector, aligns the golden value to the DUT latency, and compares them. It counts vectors and mismatches and captures the first failing vector. The fault campaign controller reads the pass/fail summary after each run.

---
 rtl/fault_response_checker_if.sv | 41 ++++
 rtl/fault_response_checker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fault_response_checker_if.sv
// Signal bundle between the fault-injection harness, the response checker and the campaign controller.
// Defining FAIL_BITMAP_EN adds the sticky per-bit fail_bitmap signal.
interface fault_response_checker_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 32
);
  logic             start;
  logic             vec_valid;
  logic             vec_last;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic             first_fail_valid;
  logic [CNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] first_fail_diff;
`ifdef FAIL_BITMAP_EN
  logic [WIDTH-1:0] fail_bitmap;
`endif

  modport master (
    output start, vec_valid, vec_last, expected, dut_out,
`ifdef FAIL_BITMAP_EN
    input  fail_bitmap,
`endif
    input  busy, done, pass, vec_count, err_count,
           first_fail_valid, first_fail_idx, first_fail_diff
  );

  modport slave (
    input  start, vec_valid, vec_last, expected, dut_out,
`ifdef FAIL_BITMAP_EN
    output fail_bitmap,
`endif
    output busy, done, pass, vec_count, err_count,
           first_fail_valid, first_fail_idx, first_fail_diff
  );
endinterface

// File: rtl/fault_response_checker.sv
// Aligns golden values to the DUT latency, compares them, and tallies vectors, mismatches and the first failure.
// Optional FAIL_BITMAP_EN: accumulates expected^dut_out over the run on fail_bitmap.
module fault_response_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  fault_response_checker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             accept, start_ok;
  logic             tail_valid, tail_last;
  logic [WIDTH-1:0] tail_exp, diff;
  logic             cmp_last, mismatch;
  logic [CNT_W-1:0] vec_count, err_count, first_fail_idx;
  logic             first_fail_valid;
  logic [WIDTH-1:0] first_fail_diff;

  assign accept   = (state == S_RUN) && bus.vec_valid;
  assign start_ok = bus.start && ((state == S_IDLE) || (state == S_DONE));

  // Golden values travel alongside the DUT pipeline so they meet dut_out in the compare cycle.
  generate
    if (LATENCY == 0) begin : g_nodelay
      assign tail_valid = accept;
      assign tail_last  = bus.vec_last;
      assign tail_exp   = bus.expected;
    end else begin : g_delay
      logic [LATENCY-1:0] dl_valid, dl_last;
      logic [WIDTH-1:0]   dl_exp [LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid <= '0;
          dl_last  <= '0;
          for (int i = 0; i < LATENCY; i++) dl_exp[i] <= '0;
        end else begin
          dl_valid[0] <= accept;
          dl_last[0]  <= bus.vec_last;
          dl_exp[0]   <= bus.expected;
          for (int i = 1; i < LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_last[i]  <= dl_last[i-1];
            dl_exp[i]   <= dl_exp[i-1];
          end
        end
      end

      assign tail_valid = dl_valid[LATENCY-1];
      assign tail_last  = dl_last[LATENCY-1];
      assign tail_exp   = dl_exp[LATENCY-1];
    end
  endgenerate

  assign diff     = tail_exp ^ bus.dut_out;
  assign mismatch = |diff;
  assign cmp_last = tail_valid && tail_last;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // With zero latency the last vector is compared while still in RUN, so RUN can jump straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (cmp_last)                       state_nxt = S_DONE;
        else if (accept && bus.vec_last)    state_nxt = S_DRAIN;
      end
      S_DRAIN: if (cmp_last) state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_RUN) || (state == S_DRAIN);
    bus.done = (state == S_DONE);
    bus.pass = (state == S_DONE) && (err_count == '0);
  end

  // Once vec_count saturates the index is no longer meaningful, so capture stops as well.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      vec_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_diff  <= '0;
    end else if (tail_valid) begin
      if (vec_count != CNT_MAX) vec_count <= vec_count + 1'b1;
      if (mismatch) begin
        if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        if (!first_fail_valid && (vec_count != CNT_MAX)) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= vec_count;
          first_fail_diff  <= diff;
        end
      end
    end
  end

`ifdef FAIL_BITMAP_EN
  logic [WIDTH-1:0] fail_bitmap;

  always_ff @(posedge clk) begin
    if (rst || start_ok)  fail_bitmap <= '0;
    else if (tail_valid)  fail_bitmap <= fail_bitmap | diff;
  end

  assign bus.fail_bitmap = fail_bitmap;
`endif

  assign bus.vec_count        = vec_count;
  assign bus.err_count        = err_count;
  assign bus.first_fail_valid = first_fail_valid;
  assign bus.first_fail_idx   = first_fail_idx;
  assign bus.first_fail_diff  = first_fail_diff;
endmodule
